// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Operands are latched onto the ALU for ALU_LAT cycles, then a registered result is offered.
module alu_share_ctrl #(
    parameter int WIDTH   = 4,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OPW-1:0]   r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OPW-1:0]   r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic [3:0] cnt;

    // Tie-break favours the requester that was not granted last time.
    always_comb begin
        state_nxt = state;
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    r0_ready = r0_valid & (~r1_valid | last_grant);
                    r1_ready = r1_valid & (~r0_valid | ~last_grant);
                end
                if (r0_ready || r1_ready) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (r0_ready) begin
                        alu_op     <= r0_op;
                        alu_a      <= r0_a;
                        alu_b      <= r0_b;
                        rsp_id     <= 1'b0;
                        last_grant <= 1'b0;
                        cnt        <= CNT_INIT;
                    end else if (r1_ready) begin
                        alu_op     <= r1_op;
                        alu_a      <= r1_a;
                        alu_b      <= r1_b;
                        rsp_id     <= 1'b1;
                        last_grant <= 1'b1;
                        cnt        <= CNT_INIT;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_y     <= alu_y;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: DUT 0 runs with ALU_LAT=1, DUT 1 with ALU_LAT=3.
// A behavioural ALU (AND/OR/ADD) closes the loop on each instance.
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // DUT 0 signals (ALU_LAT = 1)
    logic       r0_valid, r0_ready, r1_valid, r1_ready;
    logic [2:0] r0_op, r1_op, alu_op;
    logic [3:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_y, rsp_y;
    logic       rsp_valid, rsp_ready, rsp_id, busy;

    // DUT 1 signals (ALU_LAT = 3)
    logic       s_r0_valid, s_r0_ready, s_r1_valid, s_r1_ready;
    logic [2:0] s_r0_op, s_r1_op, s_alu_op;
    logic [3:0] s_r0_a, s_r0_b, s_r1_a, s_r1_b, s_alu_a, s_alu_b, s_alu_y, s_rsp_y;
    logic       s_rsp_valid, s_rsp_ready, s_rsp_id, s_busy;

    function automatic logic [3:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            default: return a + b;
        endcase
    endfunction

    assign alu_y   = alu_model(alu_op, alu_a, alu_b);
    assign s_alu_y = alu_model(s_alu_op, s_alu_a, s_alu_b);

    alu_share_ctrl #(.WIDTH(4), .OPW(3), .ALU_LAT(1)) dut0 (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .busy(busy)
    );

    alu_share_ctrl #(.WIDTH(4), .OPW(3), .ALU_LAT(3)) dut1 (
        .clk(clk), .rst(rst),
        .r0_valid(s_r0_valid), .r0_ready(s_r0_ready), .r0_op(s_r0_op), .r0_a(s_r0_a),
        .r0_b(s_r0_b),
        .r1_valid(s_r1_valid), .r1_ready(s_r1_ready), .r1_op(s_r1_op), .r1_a(s_r1_a),
        .r1_b(s_r1_b),
        .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_y(s_alu_y),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id), .rsp_y(s_rsp_y),
        .busy(s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [2:0] op0, input logic [3:0] a0,
                                 input logic [3:0] b0, input logic v1, input logic [2:0] op1,
                                 input logic [3:0] a1, input logic [3:0] b1);
        r0_valid = v0; r0_op = op0; r0_a = a0; r0_b = b0;
        r1_valid = v1; r1_op = op1; r1_a = a1; r1_b = b1;
        #1;
    endtask

    // One complete ALU_LAT=1 operation on DUT 0 with rsp_ready held high.
    task automatic serveOne(input string tag, input logic id, input logic [3:0] y);
        checkOutput({tag, ".r0_ready"}, r0_ready, !id);
        checkOutput({tag, ".r1_ready"}, r1_ready, id);
        tick();
        checkOutput({tag, ".busy_exec"}, busy, 1'b1);
        checkOutput({tag, ".ready_exec"}, {r0_ready, r1_ready}, 2'b00);
        checkOutput({tag, ".rsp_valid_exec"}, rsp_valid, 1'b0);
        tick();
        checkOutput({tag, ".rsp_valid"}, rsp_valid, 1'b1);
        checkOutput({tag, ".rsp_id"}, rsp_id, id);
        checkOutput({tag, ".rsp_y"}, rsp_y, y);
        tick();
        checkOutput({tag, ".rsp_valid_done"}, rsp_valid, 1'b0);
        checkOutput({tag, ".busy_done"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 3'b000, 4'hF, 4'hF, 1'b1, 3'b000, 4'hF, 4'hF);
        s_r0_valid = 1'b0; s_r0_op = '0; s_r0_a = '0; s_r0_b = '0;
        s_r1_valid = 1'b0; s_r1_op = '0; s_r1_a = '0; s_r1_b = '0;
        s_rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state, readys forced low while rst is high
        checkOutput("rst.ready", {r0_ready, r1_ready}, 2'b00);
        checkOutput("rst.busy", busy, 1'b0);
        checkOutput("rst.rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst.alu", {alu_op, alu_a, alu_b}, 11'd0);
        checkOutput("rst.rsp", {rsp_id, rsp_y}, 5'd0);
        checkOutput("rst.dut1_busy", s_busy, 1'b0);

        // Test 1: single r0 AND
        rst = 1'b0;
        rsp_ready = 1'b1;
        applyStimulus(1'b1, 3'b000, 4'hF, 4'hF, 1'b0, 3'b000, 4'h0, 4'h0);
        checkOutput("t1.r0_ready", r0_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 3'b000, 4'h0, 4'h0);
        checkOutput("t1.busy", busy, 1'b1);
        checkOutput("t1.alu_a", alu_a, 4'hF);
        checkOutput("t1.rsp_valid_early", rsp_valid, 1'b0);
        tick();
        checkOutput("t1.rsp_valid", rsp_valid, 1'b1);
        checkOutput("t1.rsp_id", rsp_id, 1'b0);
        checkOutput("t1.rsp_y", rsp_y, 4'hF);
        tick();
        checkOutput("t1.rsp_valid_done", rsp_valid, 1'b0);
        checkOutput("t1.busy_done", busy, 1'b0);

        // Test 6: lone r1 granted back-to-back, OR 1000|0001
        applyStimulus(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 3'b001, 4'h8, 4'h1);
        serveOne("t6.op0", 1'b1, 4'h9);
        serveOne("t6.op1", 1'b1, 4'h9);
        serveOne("t6.op2", 1'b1, 4'h9);

        // Test 2: both valid, last grant was r1 so r0 wins first, then alternate
        applyStimulus(1'b1, 3'b000, 4'hA, 4'hA, 1'b1, 3'b000, 4'h4, 4'h0);
        serveOne("t2.op0", 1'b0, 4'hA);
        serveOne("t2.op1", 1'b1, 4'h0);
        serveOne("t2.op2", 1'b0, 4'hA);
        serveOne("t2.op3", 1'b1, 4'h0);

        // Test 3: response backpressure, r0 OR 0011|0100 = 0111
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 3'b001, 4'h3, 4'h4, 1'b0, 3'b000, 4'h0, 4'h0);
        checkOutput("t3.r0_ready", r0_ready, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3.hold_valid", rsp_valid, 1'b1);
            checkOutput("t3.hold_y", rsp_y, 4'h7);
            checkOutput("t3.hold_id", rsp_id, 1'b0);
            checkOutput("t3.hold_busy", busy, 1'b1);
            checkOutput("t3.hold_ready", {r0_ready, r1_ready}, 2'b00);
            tick();
        end
        applyStimulus(1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 3'b000, 4'h0, 4'h0);
        rsp_ready = 1'b1;
        tick();
        checkOutput("t3.rsp_valid_done", rsp_valid, 1'b0);
        checkOutput("t3.busy_done", busy, 1'b0);

        // Test 5: reset during EXEC aborts the operation
        applyStimulus(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 3'b000, 4'hF, 4'h3);
        checkOutput("t5.r1_ready", r1_ready, 1'b1);
        tick();
        checkOutput("t5.busy_exec", busy, 1'b1);
        applyStimulus(1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 3'b000, 4'h0, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5.busy", busy, 1'b0);
        checkOutput("t5.rsp_valid", rsp_valid, 1'b0);
        checkOutput("t5.alu", {alu_op, alu_a, alu_b}, 11'd0);
        checkOutput("t5.rsp", {rsp_id, rsp_y}, 5'd0);
        tick();
        tick();
        checkOutput("t5.no_rsp", rsp_valid, 1'b0);
        applyStimulus(1'b1, 3'b001, 4'h2, 4'h4, 1'b0, 3'b000, 4'h0, 4'h0);
        serveOne("t5.after", 1'b0, 4'h6);
        applyStimulus(1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 3'b000, 4'h0, 4'h0);

        // Test 4: ALU_LAT=3 on DUT 1, r1 OR 1000|0001
        s_rsp_ready = 1'b1;
        s_r1_valid = 1'b1; s_r1_op = 3'b001; s_r1_a = 4'h8; s_r1_b = 4'h1;
        #1;
        checkOutput("t4.r1_ready", s_r1_ready, 1'b1);
        tick();
        s_r1_valid = 1'b0; s_r1_op = 3'b000; s_r1_a = 4'h0; s_r1_b = 4'h0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t4.alu_hold", {s_alu_op, s_alu_a, s_alu_b}, {3'b001, 4'h8, 4'h1});
            checkOutput("t4.rsp_valid_early", s_rsp_valid, 1'b0);
            checkOutput("t4.busy", s_busy, 1'b1);
            tick();
        end
        checkOutput("t4.rsp_valid", s_rsp_valid, 1'b1);
        checkOutput("t4.rsp_y", s_rsp_y, 4'h9);
        checkOutput("t4.rsp_id", s_rsp_id, 1'b1);
        tick();
        checkOutput("t4.rsp_valid_done", s_rsp_valid, 1'b0);
        checkOutput("t4.busy_done", s_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
